bfcpu_io_monitor: RTL

Parametrised, synthesizable bus-activity monitor that sits beside the `tt_um_mgyenik_bfcpu` top level in the bench and in FPGA bring-up builds. It watches NCH 8-bit channels, for example `uo_out`, `uio_out` and `uio_oe`. Each cycle on which any channel changes, it pushes a timestamped change record into a DEPTH-entry FIFO. A host or cocotb drains the FIFO over a valid/ready port, so cocotb no longer needs to poll the raw wires every cycle.

---
 rtl/bfcpu_mon_pkg.sv | 17 +
 rtl/bfcpu_sync_fifo.sv | 73 +++++++
 rtl/bfcpu_io_monitor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bfcpu_mon_pkg.sv
// Shared types and helpers for the bfcpu I/O activity monitor.
package bfcpu_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FROZEN
    } mon_state_e;

    localparam int unsigned DROP_MAX = 255;

    // Record layout: {ts, chg_mask[nch-1:0], ch_values[8*nch-1:0]}
    function automatic int unsigned rec_w(input int unsigned nch, input int unsigned ts_w);
        return ts_w + nch + 8 * nch;
    endfunction

endpackage

// File: rtl/bfcpu_sync_fifo.sv
// Single-clock FIFO with a registered head word; a full FIFO still accepts a push
// when a pop happens in the same cycle.
module bfcpu_sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  head_q, head_d;
    logic          do_push, do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = head_q;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LW'(1);
        end
        // New head is the word being written when it lands at the read pointer
        if (level_d == '0) begin
            head_d = '0;
        end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/bfcpu_io_monitor.sv
// Watches NCH 8-bit channels and queues a timestamped record on every cycle where
// any channel changes; records are drained over a valid/ready port.
module bfcpu_io_monitor
    import bfcpu_mon_pkg::*;
#(
    parameter int unsigned NCH          = 3,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned TS_W         = 16,
    parameter int unsigned STOP_ON_FULL = 0,
    localparam int unsigned RW          = rec_w(NCH, TS_W),
    localparam int unsigned LW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [8*NCH-1:0] ch_in,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [RW-1:0]    rd_data,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic [7:0]       drop_cnt,
    output logic             frozen
);

    mon_state_e       state_q, state_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [8*NCH-1:0] prev_q, prev_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic [NCH-1:0]   chg_mask;
    logic [NCH-1:0]   rec_mask;
    logic             push_req;
    logic             lost;
    logic             fifo_full;
    logic             fifo_empty;

    always_comb begin
        for (int k = 0; k < int'(NCH); k++) begin
            chg_mask[k] = (ch_in[8*k +: 8] != prev_q[8*k +: 8]);
        end
    end

    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q;
        prev_d     = prev_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        push_req   = 1'b0;
        rec_mask   = chg_mask;

        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d    = ARMED;
                    ts_d       = '0;
                    overflow_d = 1'b0;
                    drop_cnt_d = '0;
                    prev_d     = ch_in;
                    push_req   = 1'b1;
                    rec_mask   = '1;
                end
            end
            ARMED: begin
                if (!arm) begin
                    state_d = IDLE;
                end else begin
                    ts_d     = ts_q + TS_W'(1);
                    prev_d   = ch_in;
                    push_req = |chg_mask;
                end
            end
            FROZEN: begin
                if (!arm) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees a slot, so only a blocked push counts as lost
        lost = push_req && fifo_full && !(rd_valid && rd_ready);
        if (lost) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != 8'(DROP_MAX)) begin
                drop_cnt_d = drop_cnt_d + 8'd1;
            end
            if (STOP_ON_FULL != 0) begin
                state_d = FROZEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            prev_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    bfcpu_sync_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data ({ts_d, rec_mask, ch_in}),
        .pop       (rd_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level),
        .head      (rd_data)
    );

    assign rd_valid = !fifo_empty;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign frozen   = (state_q == FROZEN);

endmodule
